seven_seg_scan: RTL and testbench

- Downstream display stage for the lab datapath.
- Takes a multi-digit hex value, such as an N-bit counter's count or an ALU result zero-extended to 4*N_DIGITS bits, and time-multiplexes it onto a common-anode 7-segment display.
- Each frame uses a tear-free snapshot, optionally blanks leading zeros, and inserts an anti-ghosting blank slot at every digit switch.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/hex_to_7seg.sv | 11 +
 rtl/seven_seg_scan.sv | 96 +++++++++
 tb/tb_seven_seg_scan.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment types and the active-low hex glyph table for the display path.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_BLANK = 7'h7F;

   // Segment order {g,f,e,d,c,b,a}, a lit segment is driven 0.
   localparam seg7_t SEG_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic seg7_t nibble_to_seg(input logic [3:0] nibble);
      return SEG_HEX[nibble];
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_7seg
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output seg7_t      seg
);

   assign seg = nibble_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode 7-segment driver with per-frame snapshot,
// leading-zero blanking and a one-cycle blank slot at every digit switch.
module seven_seg_scan
   import seg7_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp_mask,
   output logic [N_DIGITS-1:0]   anodes,
   output logic [6:0]            segments,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [PW-1:0]           prescaler;
   logic [IW-1:0]           idx;
   logic [4*N_DIGITS-1:0]   snapshot;

   logic                    tick;
   logic                    last_digit;
   logic [3:0]              nibble_sel;
   seg7_t                   seg_dec;
   logic                    lz_blank;
   logic [N_DIGITS-1:0]     digit_onehot;
   logic                    dp_sel;

   logic [N_DIGITS-1:0]     anodes_p1;
   seg7_t                   segments_p1;
   logic                    dp_p1;
   logic                    frame_done_p1;

   assign tick         = (prescaler == PW'(REFRESH_DIV - 1));
   assign last_digit   = (idx == IW'(N_DIGITS - 1));
   assign nibble_sel   = 4'(snapshot >> (4 * idx));
   assign digit_onehot = N_DIGITS'(1) << idx;
   assign dp_sel       = |(dp_mask & digit_onehot);

   // Digit idx is a leading zero when it and every nibble above it are zero.
   assign lz_blank = (BLANK_LEADING != 0) && (idx != '0) &&
                     ((snapshot >> (4 * idx)) == '0);

   hex_to_7seg u_dec (
      .nibble (nibble_sel),
      .seg    (seg_dec)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescaler <= '0;
         idx       <= '0;
         snapshot  <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            idx <= last_digit ? '0 : idx + 1'b1;
            if (last_digit)
               snapshot <= value;
         end
      end
   end

   // Output register stage: the tick edge forces the anti-ghost blank slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         anodes_p1     <= '1;
         segments_p1   <= SEG_BLANK;
         dp_p1         <= 1'b1;
         frame_done_p1 <= 1'b0;
      end else begin
         frame_done_p1 <= tick && last_digit;
         if (tick) begin
            anodes_p1   <= '1;
            segments_p1 <= SEG_BLANK;
            dp_p1       <= 1'b1;
         end else begin
            anodes_p1   <= ~digit_onehot;
            segments_p1 <= lz_blank ? SEG_BLANK : seg_dec;
            dp_p1       <= ~dp_sel;
         end
      end
   end

   assign anodes     = anodes_p1;
   assign segments   = segments_p1;
   assign dp         = dp_p1;
   assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with N_DIGITS=4, REFRESH_DIV=4.
module tb_seven_seg_scan;

   localparam int ND  = 4;
   localparam int DIV = 4;
   localparam int FRAME = ND * DIV;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [15:0]   value = 16'h1234;
   logic [3:0]    dp_mask = 4'b0000;
   logic [3:0]    anodes;
   logic [6:0]    segments;
   logic          dp;
   logic          frame_done;

   int tests  = 0;
   int failed = 0;

   logic [15:0] snap_cur;
   logic [15:0] snap_next;

   localparam logic [6:0] HEX_T [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   seven_seg_scan #(
      .N_DIGITS      (ND),
      .REFRESH_DIV   (DIV),
      .BLANK_LEADING (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .dp_mask    (dp_mask),
      .anodes     (anodes),
      .segments   (segments),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input logic [15:0] s, input int d);
      logic [3:0] nib;
      if (d > 0 && (s >> (4 * d)) == 16'h0) return 7'h7F;
      nib = s[4*d +: 4];
      return HEX_T[nib];
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests++; if (anodes !== 4'hF) begin failed++; $display("FAIL reset_anodes got %h want F", anodes); end
      tests++; if (segments !== 7'h7F) begin failed++; $display("FAIL reset_segments got %h want 7F", segments); end
      tests++; if (dp !== 1'b1) begin failed++; $display("FAIL reset_dp got %b want 1", dp); end
      tests++; if (frame_done !== 1'b0) begin failed++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      @(negedge clk);
      reset = 1'b1;
      snap_cur = 16'h0000;
   endtask

   // Frame 0 after reset shows the zero snapshot; value 1234 is captured at its end.
   task automatic test_first_frame();
      for (int k = 1; k <= FRAME; k++) begin
         int d, slot;
         logic [3:0] ea; logic [6:0] es;
         if (k == FRAME) snap_next = value;
         @(posedge clk); #1;
         d = (k - 1) / DIV; slot = (k - 1) % DIV;
         ea = (slot == DIV - 1) ? 4'hF : ~(4'b0001 << d);
         es = (slot == DIV - 1) ? 7'h7F : exp_seg(snap_cur, d);
         tests++; if (anodes !== ea) begin failed++; $display("FAIL first_anodes k=%0d got %b want %b", k, anodes, ea); end
         tests++; if (segments !== es) begin failed++; $display("FAIL first_segments k=%0d got %h want %h", k, segments, es); end
         tests++; if (frame_done !== (k == FRAME)) begin failed++; $display("FAIL first_frame_done k=%0d got %b", k, frame_done); end
      end
      snap_cur = snap_next;
   endtask

   // Shows 1234 and checks the 3-lit/1-blank slot pattern; queues 00A0.
   task automatic test_slot_timing();
      int lit [4];
      for (int i = 0; i < 4; i++) lit[i] = 0;
      value = 16'h00A0;
      for (int k = 1; k <= FRAME; k++) begin
         int d, slot;
         logic [6:0] es;
         if (k == FRAME) snap_next = value;
         @(posedge clk); #1;
         d = (k - 1) / DIV; slot = (k - 1) % DIV;
         es = (slot == DIV - 1) ? 7'h7F : exp_seg(snap_cur, d);
         if (anodes == ~(4'b0001 << d)) lit[d]++;
         tests++; if (segments !== es) begin failed++; $display("FAIL hex_segments k=%0d got %h want %h", k, segments, es); end
         if (slot == DIV - 1) begin
            tests++; if (anodes !== 4'hF) begin failed++; $display("FAIL blank_slot_anodes k=%0d got %b want 1111", k, anodes); end
         end
         tests++; if (frame_done !== (k == FRAME)) begin failed++; $display("FAIL period_frame_done k=%0d got %b", k, frame_done); end
      end
      for (int i = 0; i < 4; i++) begin
         tests++; if (lit[i] != DIV - 1) begin failed++; $display("FAIL lit_cycles digit%0d got %0d want %0d", i, lit[i], DIV - 1); end
      end
      snap_cur = snap_next;
   endtask

   // Shows 00A0 with leading-zero blanking while value churns every cycle.
   task automatic test_blanking();
      logic [6:0] want [4] = '{7'h40, 7'h08, 7'h7F, 7'h7F};
      for (int k = 1; k <= FRAME; k++) begin
         int d, slot;
         logic [3:0] ea; logic [6:0] es;
         value = 16'($urandom);
         if (k == FRAME) snap_next = value;
         @(posedge clk); #1;
         d = (k - 1) / DIV; slot = (k - 1) % DIV;
         ea = (slot == DIV - 1) ? 4'hF : ~(4'b0001 << d);
         es = (slot == DIV - 1) ? 7'h7F : want[d];
         tests++; if (anodes !== ea) begin failed++; $display("FAIL lz_anodes k=%0d got %b want %b", k, anodes, ea); end
         tests++; if (segments !== es) begin failed++; $display("FAIL lz_segments k=%0d got %h want %h", k, segments, es); end
      end
      snap_cur = snap_next;
   endtask

   // The frame shows only the value sampled on the last snapshot tick.
   task automatic test_no_mix();
      for (int k = 1; k <= FRAME; k++) begin
         int d, slot;
         logic [6:0] es;
         value = 16'($urandom);
         if (k == FRAME) snap_next = value;
         @(posedge clk); #1;
         d = (k - 1) / DIV; slot = (k - 1) % DIV;
         es = (slot == DIV - 1) ? 7'h7F : exp_seg(snap_cur, d);
         tests++; if (segments !== es) begin failed++; $display("FAIL nomix_segments k=%0d snap=%h got %h want %h", k, snap_cur, segments, es); end
      end
      snap_cur = snap_next;
      value = 16'h8F0C;
   endtask

   task automatic test_dp();
      dp_mask = 4'b0100;
      for (int k = 1; k <= FRAME; k++) begin
         int d, slot;
         logic edp;
         if (k == FRAME) snap_next = value;
         @(posedge clk); #1;
         d = (k - 1) / DIV; slot = (k - 1) % DIV;
         edp = (slot == DIV - 1) ? 1'b1 : ~dp_mask[d];
         tests++; if (dp !== edp) begin failed++; $display("FAIL dp k=%0d anodes=%b got %b want %b", k, anodes, dp, edp); end
         if (dp === 1'b0) begin
            tests++; if (anodes !== 4'b1011) begin failed++; $display("FAIL dp_anodes k=%0d got %b want 1011", k, anodes); end
         end
      end
      snap_cur = snap_next;
      dp_mask = 4'b0000;
   endtask

   task automatic test_mid_reset();
      repeat (9) @(posedge clk);
      #1;
      tests++; if (anodes !== 4'b1011) begin failed++; $display("FAIL pre_reset_anodes got %b want 1011", anodes); end
      #2 reset = 1'b0;
      #1;
      tests++; if (anodes !== 4'hF) begin failed++; $display("FAIL async_anodes got %b want 1111", anodes); end
      tests++; if (segments !== 7'h7F) begin failed++; $display("FAIL async_segments got %h want 7F", segments); end
      tests++; if (dp !== 1'b1) begin failed++; $display("FAIL async_dp got %b want 1", dp); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         int d, slot;
         logic [3:0] ea; logic [6:0] es;
         @(posedge clk); #1;
         d = (k - 1) / DIV; slot = (k - 1) % DIV;
         ea = (slot == DIV - 1) ? 4'hF : ~(4'b0001 << d);
         es = (slot == DIV - 1) ? 7'h7F : exp_seg(16'h0000, d);
         tests++; if (anodes !== ea) begin failed++; $display("FAIL restart_anodes k=%0d got %b want %b", k, anodes, ea); end
         tests++; if (segments !== es) begin failed++; $display("FAIL restart_segments k=%0d got %h want %h", k, segments, es); end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_slot_timing();
      test_blanking();
      test_no_mix();
      test_dp();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
